reu_dma_seq: RTL and testbench

DMA sequencer for the REU CPLD. It consumes the command/status register block's Execute, transfer type and length-terminal indications. It runs stash, fetch, swap and verify transfers byte by byte between the C64 bus and the REU SDRAM controller. It returns the per-byte increment, decrement and end-of-transfer strobes that the register block applies on the same falling PHI2 edge.

---
 rtl/reu_dma_seq.sv | 161 ++++++++++++++++
 tb/tb_reu_dma_seq.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reu_dma_seq.sv
// REU DMA sequencer: byte-wise stash/fetch/swap/verify between C64 bus and SDRAM.
// All state advances on the falling PHI2 edge; per-byte strobes are Mealy.
module reu_dma_seq (
  input  logic       PHI2,
  input  logic       Reset,
  input  logic       Execute,
  input  logic [1:0] XferType,
  input  logic       Length1,
  input  logic       BA,
  input  logic [7:0] CDIn,
  input  logic [7:0] RAMDIn,
  input  logic       RAMAck,
  output logic       DMA,
  output logic       CRnW,
  output logic       CDOE,
  output logic [7:0] CDOut,
  output logic       RAMRD,
  output logic       RAMWR,
  output logic [7:0] RAMDOut,
  output logic       IncCA,
  output logic       IncREUA,
  output logic       DecLen,
  output logic       XferEnd,
  output logic       SetEndOfBlock,
  output logic       SetVerifyErr,
  output logic       Busy
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StC64Rd,
    StRamRd,
    StRamWr,
    StC64Wr,
    StDone
  } state_t;

  localparam logic [1:0] TStash  = 2'b00;
  localparam logic [1:0] TFetch  = 2'b01;
  localparam logic [1:0] TSwap   = 2'b10;
  localparam logic [1:0] TVerify = 2'b11;

  state_t     state;
  state_t     stateNext;
  state_t     firstSt;
  logic [1:0] xType;
  logic [7:0] latchC;
  logic [7:0] latchR;
  logic       byteDone;
  logic       mismatch;
  logic       ldC;
  logic       ldR;
  logic       strobe;

  always_ff @(negedge PHI2) begin
    if (Reset) begin
      state  <= StIdle;
      xType  <= TStash;
      latchC <= 8'h00;
      latchR <= 8'h00;
    end else begin
      state <= stateNext;
      if (state == StIdle && Execute)
        xType <= XferType;
      if (ldC)
        latchC <= CDIn;
      if (ldR)
        latchR <= RAMDIn;
    end
  end

  // Fetch is the only type that begins on the REU side.
  always_comb begin
    firstSt = StC64Rd;
    if (xType == TFetch)
      firstSt = StRamRd;
  end

  always_comb begin
    stateNext = state;
    byteDone  = 1'b0;
    mismatch  = 1'b0;
    ldC       = 1'b0;
    ldR       = 1'b0;
    unique case (state)
      StIdle: begin
        if (Execute)
          stateNext = StStart;
      end
      StStart: begin
        stateNext = firstSt;
      end
      StC64Rd: begin
        if (BA) begin
          ldC = 1'b1;
          if (xType == TStash)
            stateNext = StRamWr;
          else
            stateNext = StRamRd;
        end
      end
      StRamRd: begin
        if (RAMAck) begin
          ldR = 1'b1;
          if (xType == TVerify) begin
            byteDone = 1'b1;
            mismatch = (RAMDIn != latchC);
          end else if (xType == TFetch) begin
            stateNext = StC64Wr;
          end else begin
            stateNext = StRamWr;
          end
        end
      end
      StRamWr: begin
        if (RAMAck) begin
          if (xType == TSwap)
            stateNext = StC64Wr;
          else
            byteDone = 1'b1;
        end
      end
      StC64Wr: begin
        if (BA)
          byteDone = 1'b1;
      end
      StDone: begin
        stateNext = StIdle;
      end
      default: begin
        stateNext = StIdle;
      end
    endcase
    if (byteDone) begin
      if (mismatch || Length1)
        stateNext = StDone;
      else
        stateNext = firstSt;
    end
  end

  // Reset suppresses strobes so an aborted byte leaves registers untouched.
  assign strobe = byteDone && !Reset;

  assign Busy          = (state != StIdle);
  assign DMA           = Busy;
  assign CRnW          = (state == StC64Rd);
  assign CDOE          = (state == StC64Wr);
  assign CDOut         = latchR;
  assign RAMRD         = (state == StRamRd);
  assign RAMWR         = (state == StRamWr);
  assign RAMDOut       = latchC;
  assign IncCA         = strobe;
  assign IncREUA       = strobe;
  assign DecLen        = strobe && !mismatch && !Length1;
  assign XferEnd       = strobe && (mismatch || Length1);
  assign SetEndOfBlock = strobe && Length1;
  assign SetVerifyErr  = strobe && mismatch;

endmodule

// File: tb/tb_reu_dma_seq.sv
// Directed bench for reu_dma_seq with a small C64/REU memory and length model.
// Inputs change 1 time unit after each falling edge.
module tb_reu_dma_seq;

  logic       PHI2 = 1'b1;
  logic       Reset = 1'b0;
  logic       Execute = 1'b0;
  logic [1:0] XferType = 2'b00;
  logic       Length1;
  logic       BA = 1'b1;
  logic [7:0] CDIn;
  logic [7:0] RAMDIn;
  logic       RAMAck = 1'b0;
  logic       DMA;
  logic       CRnW;
  logic       CDOE;
  logic [7:0] CDOut;
  logic       RAMRD;
  logic       RAMWR;
  logic [7:0] RAMDOut;
  logic       IncCA;
  logic       IncREUA;
  logic       DecLen;
  logic       XferEnd;
  logic       SetEndOfBlock;
  logic       SetVerifyErr;
  logic       Busy;

  reu_dma_seq dut (
    .PHI2(PHI2),
    .Reset(Reset),
    .Execute(Execute),
    .XferType(XferType),
    .Length1(Length1),
    .BA(BA),
    .CDIn(CDIn),
    .RAMDIn(RAMDIn),
    .RAMAck(RAMAck),
    .DMA(DMA),
    .CRnW(CRnW),
    .CDOE(CDOE),
    .CDOut(CDOut),
    .RAMRD(RAMRD),
    .RAMWR(RAMWR),
    .RAMDOut(RAMDOut),
    .IncCA(IncCA),
    .IncREUA(IncREUA),
    .DecLen(DecLen),
    .XferEnd(XferEnd),
    .SetEndOfBlock(SetEndOfBlock),
    .SetVerifyErr(SetVerifyErr),
    .Busy(Busy)
  );

  always #10 PHI2 = ~PHI2;

  logic [7:0]  c64Mem [256];
  logic [7:0]  reuMem [256];
  logic [7:0]  caIdx = 8'h00;
  logic [7:0]  reuIdx = 8'h00;
  logic [15:0] lenReg = 16'h0000;
  logic [15:0] lenInit = 16'h0000;
  logic        lenLoad = 1'b0;
  logic        cdForce = 1'b0;
  logic [7:0]  cdVal = 8'h00;

  assign CDIn    = cdForce ? cdVal : c64Mem[caIdx];
  assign RAMDIn  = reuMem[reuIdx];
  assign Length1 = (lenReg == 16'd1);

  int incCaCnt = 0;
  int incReuCnt = 0;
  int decCnt = 0;
  int endCnt = 0;
  int eobCnt = 0;
  int errCnt = 0;
  int busyCnt = 0;
  int rdCnt = 0;
  logic [7:0] ramWrQ [$];
  logic [7:0] c64WrQ [$];

  // Register-block and bus model acting on the same edge as the DUT.
  always @(negedge PHI2) begin
    if (lenLoad)
      lenReg <= lenInit;
    else if (DecLen)
      lenReg <= lenReg - 16'd1;
    if (IncCA)         caIdx <= caIdx + 8'd1;
    if (IncREUA)       reuIdx <= reuIdx + 8'd1;
    if (IncCA)         incCaCnt <= incCaCnt + 1;
    if (IncREUA)       incReuCnt <= incReuCnt + 1;
    if (DecLen)        decCnt <= decCnt + 1;
    if (XferEnd)       endCnt <= endCnt + 1;
    if (SetEndOfBlock) eobCnt <= eobCnt + 1;
    if (SetVerifyErr)  errCnt <= errCnt + 1;
    if (Busy)          busyCnt <= busyCnt + 1;
    if (RAMRD)         rdCnt <= rdCnt + 1;
    if (RAMWR && RAMAck)
      ramWrQ.push_back(RAMDOut);
    if (CDOE && !CRnW && BA)
      c64WrQ.push_back(CDOut);
  end

  int nAsserts = 0;
  int nFail = 0;
  int sInc, sReu, sDec, sEnd, sEob, sErr, sBusy, sRd;
  int q0, c0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge PHI2);
    #1;
  endtask

  task automatic snap();
    sInc  = incCaCnt;
    sReu  = incReuCnt;
    sDec  = decCnt;
    sEnd  = endCnt;
    sEob  = eobCnt;
    sErr  = errCnt;
    sBusy = busyCnt;
    sRd   = rdCnt;
    q0    = ramWrQ.size();
    c0    = c64WrQ.size();
  endtask

  task automatic startXfer(input logic [1:0] t, input logic [15:0] len);
    XferType = t;
    lenInit  = len;
    lenLoad  = 1'b1;
    Execute  = 1'b1;
    step();
    lenLoad  = 1'b0;
    Execute  = 1'b0;
  endtask

  task automatic waitIdle(input int maxCyc, input string tag);
    int n;
    n = 0;
    while (Busy && n < maxCyc) begin
      step();
      n++;
    end
    chk(tag, {31'd0, Busy}, 32'd0);
  endtask

  function automatic logic [11:0] outVec();
    return {DMA, CRnW, CDOE, RAMRD, RAMWR, IncCA, IncREUA,
            DecLen, XferEnd, SetEndOfBlock, SetVerifyErr, Busy};
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      c64Mem[i] = 8'h00;
      reuMem[i] = 8'h00;
    end

    Reset = 1'b1;
    step();
    chk("reset_outs", {20'd0, outVec()}, 32'd0);
    chk("reset_data", {16'd0, CDOut, RAMDOut}, 32'd0);
    Reset = 1'b0;

    // Stash, length 3
    c64Mem[caIdx]        = 8'h11;
    c64Mem[caIdx + 8'd1] = 8'h22;
    c64Mem[caIdx + 8'd2] = 8'h33;
    RAMAck = 1'b1;
    snap();
    startXfer(2'b00, 16'd3);
    chk("stash_dma_start", {31'd0, DMA}, 32'd1);
    waitIdle(40, "stash_idle");
    chk("stash_wr0", {24'd0, ramWrQ[q0]}, 32'h11);
    chk("stash_wr1", {24'd0, ramWrQ[q0 + 1]}, 32'h22);
    chk("stash_wr2", {24'd0, ramWrQ[q0 + 2]}, 32'h33);
    chk("stash_incca", incCaCnt - sInc, 3);
    chk("stash_declen", decCnt - sDec, 2);
    chk("stash_xferend", endCnt - sEnd, 1);
    chk("stash_eob", eobCnt - sEob, 1);
    chk("stash_dma_cycles", busyCnt - sBusy, 8);

    // Fetch, length 1, ack on 4th request cycle
    RAMAck = 1'b0;
    reuMem[reuIdx] = 8'hA5;
    snap();
    startXfer(2'b01, 16'd1);
    step();
    chk("fetch_rdreq", {31'd0, RAMRD}, 32'd1);
    step();
    step();
    step();
    chk("fetch_rdhold", {31'd0, RAMRD}, 32'd1);
    RAMAck = 1'b1;
    step();
    RAMAck = 1'b0;
    chk("fetch_c64wr", {23'd0, CDOE, CRnW, CDOut}, {23'd0, 1'b1, 1'b0, 8'hA5});
    chk("fetch_end", {29'd0, XferEnd, DecLen, SetEndOfBlock}, 32'b101);
    waitIdle(20, "fetch_idle");
    chk("fetch_rd_cycles", rdCnt - sRd, 4);
    chk("fetch_c64data", {24'd0, c64WrQ[c0]}, 32'hA5);

    // Swap, length 2
    c64Mem[caIdx]         = 8'h01;
    c64Mem[caIdx + 8'd1]  = 8'h02;
    reuMem[reuIdx]        = 8'hF1;
    reuMem[reuIdx + 8'd1] = 8'hF2;
    RAMAck = 1'b1;
    snap();
    startXfer(2'b10, 16'd2);
    waitIdle(40, "swap_idle");
    chk("swap_ram0", {24'd0, ramWrQ[q0]}, 32'h01);
    chk("swap_ram1", {24'd0, ramWrQ[q0 + 1]}, 32'h02);
    chk("swap_c640", {24'd0, c64WrQ[c0]}, 32'hF1);
    chk("swap_c641", {24'd0, c64WrQ[c0 + 1]}, 32'hF2);
    chk("swap_increua", incReuCnt - sReu, 2);
    chk("swap_declen", decCnt - sDec, 1);
    chk("swap_dma_cycles", busyCnt - sBusy, 10);

    // Verify, length 4, mismatch on byte 2
    c64Mem[caIdx]         = 8'h10;
    c64Mem[caIdx + 8'd1]  = 8'h20;
    c64Mem[caIdx + 8'd2]  = 8'h30;
    c64Mem[caIdx + 8'd3]  = 8'h40;
    reuMem[reuIdx]        = 8'h10;
    reuMem[reuIdx + 8'd1] = 8'h2F;
    reuMem[reuIdx + 8'd2] = 8'h30;
    reuMem[reuIdx + 8'd3] = 8'h40;
    snap();
    startXfer(2'b11, 16'd4);
    waitIdle(40, "verify_idle");
    chk("verify_incca", incCaCnt - sInc, 2);
    chk("verify_declen", decCnt - sDec, 1);
    chk("verify_xferend", endCnt - sEnd, 1);
    chk("verify_err", errCnt - sErr, 1);
    chk("verify_eob", eobCnt - sEob, 0);
    chk("verify_dma_cycles", busyCnt - sBusy, 6);

    // BA stall in C64RD of a stash
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("reset2_latch", {24'd0, RAMDOut}, 32'd0);
    cdForce = 1'b1;
    cdVal = 8'h55;
    snap();
    startXfer(2'b00, 16'd1);
    step();
    BA = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cdVal = 8'h60 + 8'(k);
      #1;
      chk("stall_hold", {17'd0, DMA, CRnW, RAMWR, IncCA, IncREUA, DecLen, XferEnd, RAMDOut},
          {17'd0, 7'b1100000, 8'h00});
      step();
    end
    chk("stall_nostrobe", incCaCnt - sInc, 0);
    BA = 1'b1;
    cdVal = 8'h77;
    step();
    chk("stall_ramwr", {22'd0, RAMWR, XferEnd, RAMDOut}, {22'd0, 2'b11, 8'h77});
    cdForce = 1'b0;
    waitIdle(20, "stall_idle");
    chk("stall_wrdata", {24'd0, ramWrQ[q0]}, 32'h77);

    // Reset during swap RAMWR, then a fresh stash
    c64Mem[caIdx]  = 8'h3C;
    reuMem[reuIdx] = 8'hC3;
    RAMAck = 1'b1;
    startXfer(2'b10, 16'd2);
    step();
    step();
    step();
    chk("swap_in_ramwr", {23'd0, RAMWR, RAMDOut}, {23'd0, 1'b1, 8'h3C});
    snap();
    Reset = 1'b1;
    step();
    chk("abort_outs", {20'd0, outVec()}, 32'd0);
    chk("abort_data", {16'd0, CDOut, RAMDOut}, 32'd0);
    chk("abort_noend", endCnt - sEnd, 0);
    Reset = 1'b0;
    c64Mem[caIdx] = 8'h5A;
    snap();
    startXfer(2'b00, 16'd1);
    waitIdle(20, "fresh_idle");
    chk("fresh_wrdata", {24'd0, ramWrQ[q0]}, 32'h5A);
    chk("fresh_dma_cycles", busyCnt - sBusy, 4);
    chk("fresh_xferend", endCnt - sEnd, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
